bicubic_sched: RTL and testbench
================================

Name: bicubic_sched

Overview:
- Sequencer for the Bicubic interpolation datapath.
- Walks every target pixel (tx,ty) of a TW x TH output window and derives the source coordinate and 8-bit fractional phases from precomputed fixed-point steps.
- Fetches the clamped 4x4 source neighbourhood from the image ROM and streams it into the datapath.
- Writes each interpolated result to the result SRAM and pulses done once the whole window is finished.

Parameters:
- IMG_W, 100, source image width and height in pixels (square image).
- AW, 14, ROM/SRAM address width.
- STEP_FB, 12, fractional bits of step_x/step_y (Q4.12).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high (already decided).
- start  in  1  one-cycle request to begin; ignored unless idle.
- h0  in  7  source window left column.
- v0  in  7  source window top row.
- tw  in  7  target width, 1..IMG_W.
- th  in  7  target height, 1..IMG_W.
- step_x  in  16  Q4.12 horizontal source increment per target pixel.
- step_y  in  16  Q4.12 vertical source increment per target row.
- rom_rd  out  1  ROM read strobe.
- rom_addr  out  AW  ROM address = row*IMG_W + col.
- rom_q  in  8  ROM data, valid exactly 1 cycle after rom_rd.
- dp_start  out  1  one-cycle pulse opening a datapath job.
- dp_fx  out  8  horizontal phase; held stable from dp_start until dp_done.
- dp_fy  out  8  vertical phase; held stable from dp_start until dp_done.
- dp_pix_valid  out  1  dp_pix/dp_pix_idx valid.
- dp_pix  out  8  neighbourhood pixel.
- dp_pix_idx  out  4  index = 4*row + col of the 4x4 tap (row/col 0..3).
- dp_done  in  1  datapath result ready (single pulse).
- dp_val  in  8  datapath result, valid with dp_done.
- sram_wen  out  1  result write enable.
- sram_addr  out  AW  result address = ty*tw + tx.
- sram_d  out  8  result data.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last write.

Behaviour:
- Reset: every output is 0; FSM in IDLE; all counters and accumulators are 0. Reset asserted mid-job aborts immediately; no further ROM, datapath or SRAM strobes until the next start.
- IDLE:
  - On start, latch h0, v0, tw, th, step_x, step_y.
  - Clear tx, ty, acc_x, acc_y (19-bit unsigned accumulators).
  - Set busy and go to CALC.
- CALC (1 cycle):
  - ix = h0 + acc_x[18:12]; iy = v0 + acc_y[18:12].
  - fx = acc_x[11:4]; fy = acc_y[11:4].
  - Register dp_fx/dp_fy.
  - Go to FETCH.
- FETCH (17 cycles, k = 0..16):
  - Cycle 0: dp_start = 1.
  - Cycles k = 0..15: rom_rd = 1, with tap row r = k/4 and col c = k%4.
  - Tap column = clamp(ix-1+c, 0, IMG_W-1); tap row = clamp(iy-1+r, 0, IMG_W-1). Clamp is evaluated in signed 9-bit.
  - Cycles k = 1..16: dp_pix_valid = 1, dp_pix = rom_q, dp_pix_idx = k-1.
  - Then go to WAIT.
- WAIT:
  - Hold until dp_done.
  - Capture dp_val into sram_d; go to WRITE.
  - dp_done arriving during FETCH is a protocol error: ignore it, keep waiting.
- WRITE (1 cycle):
  - sram_wen = 1, sram_addr = ty*tw + tx.
  - Advance:
    - If tx < tw-1: tx++, acc_x += step_x.
    - Else: tx = 0, acc_x = 0, ty++, acc_y += step_y.
  - If (tx,ty) was (tw-1, th-1), go to DONE; else go to CALC.
- DONE (1 cycle): done = 1, busy = 0; return to IDLE.
- start is ignored while busy; start in the same cycle as the DONE state is also ignored.
- Arithmetic: accumulators wrap at 2^19. No saturation beyond the IMG_W-1 clamp.
- Per-pixel latency: 1 + 17 + datapath latency + 1 cycles.
- tw = th = 1: exactly one job, then done.

Optional Feature:
- Macro EXACT_HIT_BYPASS_EN.
- Defined: when fx == 0 and fy == 0, CALC goes to a BYPASS state instead of FETCH:
  - 1 ROM read at (iy clamped, ix clamped).
  - rom_q goes directly to sram_d the next cycle, then WRITE.
  - No dp_start and no dp_pix_valid for that pixel.
- Undefined: every pixel goes through FETCH/WAIT.

Test Plan:
- Reset mid-FETCH: assert rst at FETCH k = 5 -> next cycle all outputs 0; no sram_wen until a new start.
- Single pixel: h0 = 10, v0 = 20, tw = th = 1, steps 0 -> 16 reads starting at addr 19*100+9 = 1909, last at 22*100+12 = 2212; dp_pix_idx 0..15; one write to addr 0; done pulses 1 cycle after WRITE.
- Border clamp: h0 = 0, v0 = 0 -> taps at c = 0 and r = 0 read col 0 / row 0; first rom_addr = 0, the k = 4 tap reads addr 0.
- 2x2 window: tw = th = 2, step_x = step_y = 0x1800 (1.5) -> pixel (1,0) has ix = h0+1, fx = 0x80; writes go to addrs 0, 1, 2, 3 in order; done once.
- Busy start: start pulsed during WAIT -> no effect, latched config unchanged.
- EXACT_HIT_BYPASS_EN: steps 0x1000 -> with the macro, zero dp_start pulses and sram_d equals the ROM pixel; without it, dp_start is pulsed per pixel.

Source files
------------

// File: rtl/bicubic_sched.sv
// Bicubic interpolation sequencer: walks the target window, fetches clamped 4x4
// neighbourhoods from ROM into the datapath and writes results to SRAM.
// Optional `EXACT_HIT_BYPASS_EN: integer-aligned pixels skip the datapath.
module bicubic_sched #(
  parameter int IMG_W   = 100,
  parameter int AW      = 14,
  parameter int STEP_FB = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [6:0]    h0,
  input  logic [6:0]    v0,
  input  logic [6:0]    tw,
  input  logic [6:0]    th,
  input  logic [15:0]   step_x,
  input  logic [15:0]   step_y,
  output logic          rom_rd,
  output logic [AW-1:0] rom_addr,
  input  logic [7:0]    rom_q,
  output logic          dp_start,
  output logic [7:0]    dp_fx,
  output logic [7:0]    dp_fy,
  output logic          dp_pix_valid,
  output logic [7:0]    dp_pix,
  output logic [3:0]    dp_pix_idx,
  input  logic          dp_done,
  input  logic [7:0]    dp_val,
  output logic          sram_wen,
  output logic [AW-1:0] sram_addr,
  output logic [7:0]    sram_d,
  output logic          busy,
  output logic          done
);

  localparam int ACC_W = STEP_FB + 7;
  localparam logic signed [8:0] COORD_MAX = 9'(IMG_W - 1);
  localparam logic [AW-1:0]     ROW_PITCH = AW'(IMG_W);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CALC  = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
`ifdef EXACT_HIT_BYPASS_EN
  localparam logic [2:0] S_BYP    = 3'd6;
  localparam logic [2:0] S_BYPCAP = 3'd7;
`endif

  function automatic logic [6:0] clamp_coord(input logic signed [8:0] v);
    if (v < 9'sd0)
      return 7'd0;
    else if (v > COORD_MAX)
      return COORD_MAX[6:0];
    else
      return v[6:0];
  endfunction

  function automatic logic [AW-1:0] pix_addr(input logic [6:0] row, input logic [6:0] col);
    return AW'(row) * ROW_PITCH + AW'(col);
  endfunction

  logic [2:0]       state;
  logic [6:0]       h0_r, v0_r, tw_r, th_r;
  logic [15:0]      step_x_r, step_y_r;
  logic [6:0]       tx, ty;
  logic [ACC_W-1:0] acc_x, acc_y;
  logic [7:0]       ix_r, iy_r;
  logic [7:0]       fx_r, fy_r;
  logic [4:0]       k_p0;
  logic             vld_p1;
  logic [3:0]       idx_p1;
  logic [AW-1:0]    wr_addr;
  logic [7:0]       sram_d_r;

  logic [7:0]        ix_calc, iy_calc;
  logic [7:0]        fx_calc, fy_calc;
  logic signed [8:0] tap_col, tap_row;
  logic [AW-1:0]     rd_addr;
  logic              fetch_rd;
  logic              last_px;

  assign ix_calc  = {1'b0, h0_r} + {1'b0, acc_x[ACC_W-1:STEP_FB]};
  assign iy_calc  = {1'b0, v0_r} + {1'b0, acc_y[ACC_W-1:STEP_FB]};
  assign fx_calc  = acc_x[STEP_FB-1:STEP_FB-8];
  assign fy_calc  = acc_y[STEP_FB-1:STEP_FB-8];
  assign fetch_rd = (state == S_FETCH) && !k_p0[4];
  assign last_px  = (tx == tw_r - 7'd1) && (ty == th_r - 7'd1);

  // Stage p0: tap address generation from the fetch counter
  always_comb begin
    tap_col = $signed({1'b0, ix_r}) - 9'sd1 + $signed({7'd0, k_p0[1:0]});
    tap_row = $signed({1'b0, iy_r}) - 9'sd1 + $signed({7'd0, k_p0[3:2]});
    rom_rd  = fetch_rd;
`ifdef EXACT_HIT_BYPASS_EN
    if (state == S_BYP) begin
      tap_col = $signed({1'b0, ix_r});
      tap_row = $signed({1'b0, iy_r});
      rom_rd  = 1'b1;
    end
`endif
    rd_addr = pix_addr(clamp_coord(tap_row), clamp_coord(tap_col));
  end

  assign rom_addr = rom_rd ? rd_addr : '0;
  assign dp_start = (state == S_FETCH) && (k_p0 == 5'd0);
  assign dp_fx    = fx_r;
  assign dp_fy    = fy_r;

  // Stage p1: ROM data returns one cycle after the read strobe
  assign dp_pix_valid = vld_p1;
  assign dp_pix       = vld_p1 ? rom_q : '0;
  assign dp_pix_idx   = vld_p1 ? idx_p1 : '0;

  assign sram_wen  = (state == S_WRITE);
  assign sram_addr = sram_wen ? wr_addr : '0;
  assign sram_d    = sram_d_r;
  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign done      = (state == S_DONE);

  // Job configuration and per-pixel source coordinate; no reset needed
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      h0_r     <= h0;
      v0_r     <= v0;
      tw_r     <= tw;
      th_r     <= th;
      step_x_r <= step_x;
      step_y_r <= step_y;
    end
    if (state == S_CALC) begin
      ix_r <= ix_calc;
      iy_r <= iy_calc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tx       <= '0;
      ty       <= '0;
      acc_x    <= '0;
      acc_y    <= '0;
      fx_r     <= '0;
      fy_r     <= '0;
      k_p0     <= '0;
      vld_p1   <= 1'b0;
      idx_p1   <= '0;
      wr_addr  <= '0;
      sram_d_r <= '0;
    end else begin
      vld_p1 <= fetch_rd;
      idx_p1 <= k_p0[3:0];
      case (state)
        S_IDLE: begin
          if (start) begin
            tx      <= '0;
            ty      <= '0;
            acc_x   <= '0;
            acc_y   <= '0;
            wr_addr <= '0;
            state   <= S_CALC;
          end
        end
        S_CALC: begin
          fx_r <= fx_calc;
          fy_r <= fy_calc;
          k_p0 <= '0;
`ifdef EXACT_HIT_BYPASS_EN
          if (fx_calc == 8'd0 && fy_calc == 8'd0)
            state <= S_BYP;
          else
            state <= S_FETCH;
`else
          state <= S_FETCH;
`endif
        end
        S_FETCH: begin
          k_p0 <= k_p0 + 5'd1;
          if (k_p0 == 5'd16)
            state <= S_WAIT;
        end
        S_WAIT: begin
          if (dp_done) begin
            sram_d_r <= dp_val;
            state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          wr_addr <= wr_addr + AW'(1);
          if (tx < tw_r - 7'd1) begin
            tx    <= tx + 7'd1;
            acc_x <= acc_x + ACC_W'(step_x_r);
          end else begin
            tx    <= '0;
            acc_x <= '0;
            ty    <= ty + 7'd1;
            acc_y <= acc_y + ACC_W'(step_y_r);
          end
          state <= last_px ? S_DONE : S_CALC;
        end
        S_DONE: state <= S_IDLE;
`ifdef EXACT_HIT_BYPASS_EN
        S_BYP: state <= S_BYPCAP;
        S_BYPCAP: begin
          sram_d_r <= rom_q;
          state    <= S_WRITE;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bicubic_sched.sv
// Scoreboard bench for bicubic_sched: ROM and datapath responders plus a
// reference walk of the window that queues expected reads, jobs and writes.
module tb_bicubic_sched;
  localparam int IMG_W = 100;
  localparam int AW    = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [6:0]    h0 = '0, v0 = '0, tw = 7'd1, th = 7'd1;
  logic [15:0]   step_x = '0, step_y = '0;
  logic          rom_rd;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_q = '0;
  logic          dp_start;
  logic [7:0]    dp_fx, dp_fy;
  logic          dp_pix_valid;
  logic [7:0]    dp_pix;
  logic [3:0]    dp_pix_idx;
  logic          dp_done = 1'b0;
  logic [7:0]    dp_val = '0;
  logic          sram_wen;
  logic [AW-1:0] sram_addr;
  logic [7:0]    sram_d;
  logic          busy, done;

  always #5 clk = ~clk;

  bicubic_sched #(.IMG_W(IMG_W), .AW(AW), .STEP_FB(12)) dut (
    .clk(clk), .rst(rst), .start(start),
    .h0(h0), .v0(v0), .tw(tw), .th(th), .step_x(step_x), .step_y(step_y),
    .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_q(rom_q),
    .dp_start(dp_start), .dp_fx(dp_fx), .dp_fy(dp_fy),
    .dp_pix_valid(dp_pix_valid), .dp_pix(dp_pix), .dp_pix_idx(dp_pix_idx),
    .dp_done(dp_done), .dp_val(dp_val),
    .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_d(sram_d),
    .busy(busy), .done(done)
  );

  int n_vec = 0, n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rom_f(input int a);
    return 8'((a * 37) ^ (a >> 7) ^ 8'h5a);
  endfunction

  function automatic int clampc(input int v);
    if (v < 0) return 0;
    if (v > IMG_W - 1) return IMG_W - 1;
    return v;
  endfunction

  function automatic bit is_bypass(input int fx, input int fy);
`ifdef EXACT_HIT_BYPASS_EN
    return (fx == 0) && (fy == 0);
`else
    return 1'b0;
`endif
  endfunction

  // ROM: data one cycle after the read strobe
  always @(posedge clk) if (rom_rd) rom_q <= rom_f(int'(rom_addr));

  // Datapath: weighted tap sum, result 4 cycles after the last tap
  int   dp_sum = 0, dp_cnt = 0;
  logic inject_early = 1'b0;
  always @(posedge clk) begin
    dp_done <= 1'b0;
    if (rst) begin
      dp_cnt <= 0;
      dp_sum <= 0;
    end else begin
      if (dp_start) begin
        dp_sum <= 0;
        if (inject_early) begin
          dp_done <= 1'b1;
          dp_val  <= 8'hee;
        end
      end
      if (dp_pix_valid) begin
        dp_sum <= dp_sum + int'(dp_pix) * (int'(dp_pix_idx) + 1);
        if (dp_pix_idx == 4'd15) dp_cnt <= 4;
      end
      if (dp_cnt > 0) begin
        dp_cnt <= dp_cnt - 1;
        if (dp_cnt == 1) begin
          dp_done <= 1'b1;
          dp_val  <= 8'(dp_sum + int'(dp_fx) + 3 * int'(dp_fy));
        end
      end
    end
  end

  logic [13:0] exp_rd[$];
  logic [15:0] exp_st[$];
  logic [21:0] exp_wr[$];
  int   cyc = 0, st_cnt = 0, wen_cnt = 0, rd_cnt = 0, done_cnt = 0;
  int   pix_exp = 0, last_wen_cyc = 0;
  logic sb_en = 1'b1;
  logic [7:0] cur_fx = '0, cur_fy = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (dp_start) st_cnt++;
      if (sram_wen) wen_cnt++;
      if (rom_rd)   rd_cnt++;
      if (done)     done_cnt++;
      if (sb_en) begin
        if (rom_rd) begin
          if (exp_rd.size() == 0) check_eq("rd_extra", 1, 0);
          else check_eq("rom_addr", 32'(rom_addr), 32'(exp_rd.pop_front()));
        end
        if (dp_start) begin
          pix_exp = 0;
          cur_fx  = dp_fx;
          cur_fy  = dp_fy;
          if (exp_st.size() == 0) check_eq("start_extra", 1, 0);
          else check_eq("dp_fx_fy", {dp_fx, dp_fy}, 32'(exp_st.pop_front()));
        end
        if (dp_pix_valid) begin
          check_eq("pix_idx", 32'(dp_pix_idx), pix_exp);
          pix_exp++;
        end
        if (dp_done) check_eq("phase_hold", {dp_fx, dp_fy}, {cur_fx, cur_fy});
        if (sram_wen) begin
          last_wen_cyc = cyc;
          if (exp_wr.size() == 0) check_eq("wr_extra", 1, 0);
          else check_eq("sram_wr", {sram_addr, sram_d}, 32'(exp_wr.pop_front()));
        end
        if (done) begin
          check_eq("done_lat", cyc, last_wen_cyc + 1);
          check_eq("busy_at_done", 32'(busy), 0);
        end
      end
    end
  end

  task automatic push_job(input int h, input int v, input int w, input int hh,
                          input int sx, input int sy, output int nstart);
    int ax, ay, ix, iy, fx, fy, a, sum, d;
    nstart = 0;
    ay = 0;
    for (int y = 0; y < hh; y++) begin
      ax = 0;
      for (int x = 0; x < w; x++) begin
        ix = h + ((ax >> 12) & 127);
        iy = v + ((ay >> 12) & 127);
        fx = (ax >> 4) & 255;
        fy = (ay >> 4) & 255;
        if (is_bypass(fx, fy)) begin
          a = clampc(iy) * IMG_W + clampc(ix);
          exp_rd.push_back(14'(a));
          d = int'(rom_f(a));
        end else begin
          nstart++;
          exp_st.push_back({8'(fx), 8'(fy)});
          sum = 0;
          for (int k = 0; k < 16; k++) begin
            a = clampc(iy - 1 + k / 4) * IMG_W + clampc(ix - 1 + k % 4);
            exp_rd.push_back(14'(a));
            sum += int'(rom_f(a)) * (k + 1);
          end
          d = (sum + fx + 3 * fy) & 255;
        end
        exp_wr.push_back({14'(y * w + x), 8'(d)});
        ax = (ax + sx) & 32'h7ffff;
      end
      ay = (ay + sy) & 32'h7ffff;
    end
  endtask

  task automatic run_job(input int h, input int v, input int w, input int hh,
                         input int sx, input int sy, input bit poke, input bit early);
    int nst, st0, d0, n;
    push_job(h, v, w, hh, sx, sy, nst);
    st0 = st_cnt;
    d0  = done_cnt;
    inject_early = early;
    @(negedge clk);
    h0 = 7'(h); v0 = 7'(v); tw = 7'(w); th = 7'(hh);
    step_x = 16'(sx); step_y = 16'(sy);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (poke) begin
      n = 0;
      while (!dp_start && n < 100) begin @(negedge clk); n++; end
      check_eq("poke_sync", 32'(dp_start), 1);
      repeat (17) @(negedge clk);
      check_eq("busy_in_wait", 32'(busy), 1);
      h0 = 7'd60; v0 = 7'd70; tw = 7'd9; th = 7'd9;
      step_x = 16'h3000; step_y = 16'h2000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (done_cnt == d0 && n < 4000) begin @(negedge clk); n++; end
    check_eq("job_done", 32'(done_cnt != d0), 1);
    repeat (3) @(negedge clk);
    check_eq("done_count", done_cnt - d0, 1);
    check_eq("dp_starts", st_cnt - st0, nst);
    check_eq("rd_left", exp_rd.size(), 0);
    check_eq("st_left", exp_st.size(), 0);
    check_eq("wr_left", exp_wr.size(), 0);
    exp_rd.delete();
    exp_st.delete();
    exp_wr.delete();
    inject_early = 1'b0;
  endtask

  task automatic chk_zero(input string p);
    check_eq({p, "_ctrl"}, {26'd0, rom_rd, dp_start, dp_pix_valid, sram_wen, busy, done}, 0);
    check_eq({p, "_rom_addr"}, 32'(rom_addr), 0);
    check_eq({p, "_sram_addr"}, 32'(sram_addr), 0);
    check_eq({p, "_phase"}, {dp_fx, dp_fy}, 0);
    check_eq({p, "_data"}, {dp_pix, dp_pix_idx, sram_d}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, w0, r0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    run_job(10, 20, 1, 1, 0, 0, 1'b0, 1'b0);
    run_job(0, 0, 1, 1, 0, 0, 1'b0, 1'b0);
    run_job(5, 6, 2, 2, 'h1800, 'h1800, 1'b1, 1'b0);
    run_job(30, 40, 2, 2, 'h1000, 'h1000, 1'b0, 1'b0);
    run_job(97, 97, 3, 2, 'h1400, 'h1c00, 1'b0, 1'b1);

    // Abort mid-fetch
    sb_en = 1'b0;
    @(negedge clk);
    h0 = 7'd10; v0 = 7'd20; tw = 7'd4; th = 7'd4;
    step_x = 16'h1100; step_y = 16'h1100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!dp_start && n < 100) begin @(negedge clk); n++; end
    check_eq("rst_sync", 32'(dp_start), 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("midrst");
    rst = 1'b0;
    w0 = wen_cnt;
    r0 = rd_cnt;
    repeat (60) @(negedge clk);
    check_eq("no_wen_after_rst", wen_cnt - w0, 0);
    check_eq("no_rd_after_rst", rd_cnt - r0, 0);
    check_eq("idle_after_rst", 32'(busy), 0);
    sb_en = 1'b1;

    run_job(50, 3, 3, 1, 'h0c00, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
